fetch_unit: RTL and testbench
=============================

# fetch_unit

Decoupled, parametrised instruction-fetch stage. Keeps the PC, issues in-order requests to a variable-latency instruction memory, and buffers returned instructions in a small FIFO for decode. Supports decode back-pressure, global fetch enable and branch/jump redirect with discard of stale in-flight responses. Sits between the PC-select logic and decode, replacing the single-cycle register-plus-memory fetch.

## Interface
Parameters:
- ADDR_W, 16, PC / memory address width
- INSTR_W, 16, instruction width
- PC_INC, 2, byte increment per instruction
- RESET_PC, 0, PC value after reset
- IBUF_DEPTH, 4, instruction buffer entries (power of two, ≥2)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- fetch_enable  in  1  0 = issue no new requests (in-flight ones still complete)
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  ADDR_W  request address (= fetch PC)
- imem_rsp_valid  in  1  in-order response, no back-pressure
- imem_rsp_data  in  INSTR_W  returned instruction
- out_valid  out  1  buffer head valid for decode
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  address of head instruction
- out_pc_next  out  ADDR_W  out_pc + PC_INC (mod 2^ADDR_W)
- err  out  1  sticky fetch error

## Operation
- State: fetch_pc, outstanding count (credits in flight), drop count (stale responses), FIFO of {instr, pc}.
- Issue: imem_req_valid = fetch_enable & ~redirect_valid & (fifo_count + outstanding < IBUF_DEPTH). On req handshake: fetch_pc += PC_INC (wraps), outstanding++.
- Response: if drop > 0, drop-- and data discarded; else enqueue {imem_rsp_data, pc tag}, outstanding--. Credit rule guarantees no overflow.
- Dequeue: out_valid & out_ready pops head.
- Redirect (highest priority): FIFO emptied, fetch_pc = redirect_pc, drop += outstanding (including any response arriving same cycle, which is discarded), outstanding = 0, no request and no pop that cycle; out_valid forced 0 in that cycle.
- Simultaneous req, rsp and pop without redirect: all take effect; counts updated net.
- PC tag per FIFO entry = address issued; tags kept in a small issue-order queue of depth IBUF_DEPTH.

## Timing
- Reset: fetch_pc = RESET_PC, counts 0, FIFO empty, out_valid 0, imem_req_valid 0 while rst high, err 0.
- First request the cycle after rst deasserts (if fetch_enable).
- Request accepted cycle N, response cycle N+L (L ≥ 1) → out_valid cycle N+L+1.
- Redirect in cycle R → first request to redirect_pc in cycle R+1.
- Steady state with L=1, out_ready=1: one instruction per cycle when IBUF_DEPTH ≥ 2.
- Reset mid-operation: all state cleared immediately; responses to pre-reset requests must not arrive (memory is reset too).

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect_pc not a multiple of PC_INC sets err (sticky until rst); the redirect still occurs, no requests issued while err is set.
- Undefined: err tied 0, no alignment logic.

## Structure
- Package fetch_pkg: default RESET_PC, PC_INC, ibuf entry struct {instr, pc}.
- Sub-module fetch_ibuf: synchronous circular FIFO with count, push/pop/flush, power-of-two pointer wrap.

## Test plan
- Reset, fetch_enable=1, L=1, out_ready=1 → out_pc 0,2,4,6 on consecutive cycles, out_pc_next 2,4,6,8.
- out_ready=0 for 10 cycles, IBUF_DEPTH=4 → exactly 4 requests issued, then imem_req_valid stays 0; release → PCs 0,2,4,6,8 in order.
- L=3, two in flight, redirect to 0x0100 → both stale responses dropped, next out_pc 0x0100.
- Redirect coinciding with imem_rsp_valid and out_valid&out_ready → response discarded, no pop, FIFO empty next cycle.
- fetch_pc 0xFFFE → next issued 0x0000, out_pc_next 0x0000.
- FETCH_ALIGN_CHECK_EN: redirect to 0x0101 → err=1 next cycle, no further requests until rst.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction-fetch stage.
//
// Contents:
//   FETCH_*          default parameter values used by fetch_unit
//   ibuf_entry_t     {instr, pc} pair for the default widths
//
// Optional feature macro used by fetch_unit: FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W     = 16;
  localparam int unsigned FETCH_INSTR_W    = 16;
  localparam int unsigned FETCH_PC_INC     = 2;
  localparam int unsigned FETCH_RESET_PC   = 0;
  localparam int unsigned FETCH_IBUF_DEPTH = 4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } ibuf_entry_t;

endpackage

// File: rtl/fetch_ibuf.sv
// fetch_ibuf -- synchronous circular FIFO with occupancy count.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             empties the FIFO (wins over push and pop)
//   push, push_data   write one entry
//   pop               drop the head entry (ignored when empty)
//   head_data         current head entry (combinational read)
//   count             number of valid entries, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap by overflow.
module fetch_ibuf
  import fetch_pkg::*;
#(
  parameter  int unsigned W     = 32,
  parameter  int unsigned DEPTH = FETCH_IBUF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop & (count_q != '0) & ~flush;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & ~flush & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- decoupled instruction-fetch stage.
//
// Keeps the fetch PC, issues in-order requests to a variable-latency
// instruction memory and buffers the returned instructions for decode.
// A redirect flushes the buffer, restarts at redirect_pc and discards
// responses still in flight for the old path.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   fetch_enable                    allow new requests
//   redirect_valid, redirect_pc     flush and restart fetch
//   imem_req_valid/ready, imem_addr request channel
//   imem_rsp_valid, imem_rsp_data   in-order response channel
//   out_valid/ready, out_instr,
//   out_pc, out_pc_next             head of the instruction buffer
//   err                             sticky misaligned-redirect flag
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag redirects whose
// target is not a multiple of PC_INC; while err is set no requests issue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = FETCH_ADDR_W,
  parameter int unsigned INSTR_W    = FETCH_INSTR_W,
  parameter int unsigned PC_INC     = FETCH_PC_INC,
  parameter int unsigned RESET_PC   = FETCH_RESET_PC,
  parameter int unsigned IBUF_DEPTH = FETCH_IBUF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_enable,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_next,
  output logic               err
);

  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH + 1);
  // Stale responses can pile up over back-to-back redirects while new
  // requests are already issuing, so the drop counter gets extra headroom.
  localparam int unsigned DROP_W = CNT_W + 4;
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0]  ibuf_count;
  logic [CNT_W-1:0]  tag_count;   // doubles as the outstanding-request count
  logic [ADDR_W-1:0] tag_head;
  entry_t            ibuf_push_entry;
  logic [ENTRY_W-1:0] ibuf_head_bits;
  entry_t            ibuf_head;

  logic credit_ok, align_ok, req_valid, req_fire;
  logic rsp_drop, rsp_take, rsp_owned, pop_fire;

  // Requests in flight plus buffered instructions may never exceed the
  // buffer size, so every response always finds a free slot.
  assign credit_ok = ({1'b0, ibuf_count} + {1'b0, tag_count}) < (CNT_W + 1)'(IBUF_DEPTH);
  assign req_valid = ~rst & fetch_enable & ~redirect_valid & credit_ok & align_ok;
  assign req_fire  = req_valid & imem_req_ready;

  assign rsp_drop  = imem_rsp_valid & (drop_q != '0);
  assign rsp_take  = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
  // Guards the redirect drop update against a response nobody asked for.
  assign rsp_owned = imem_rsp_valid & ((drop_q != '0) | (tag_count != '0));

  assign out_valid = (ibuf_count != '0) & ~redirect_valid;
  assign pop_fire  = out_valid & out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      // Everything in flight becomes stale, including a response landing now.
      fetch_pc_d = redirect_pc;
      drop_d     = drop_q + DROP_W'(tag_count) - DROP_W'(rsp_owned);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
      drop_d = drop_q - DROP_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= ADDR_W'(RESET_PC);
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Issue-order queue of request addresses; its head tags the next live response.
  fetch_ibuf #(
    .W     (ADDR_W),
    .DEPTH (IBUF_DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_take),
    .head_data (tag_head),
    .count     (tag_count)
  );

  assign ibuf_push_entry.instr = imem_rsp_data;
  assign ibuf_push_entry.pc    = tag_head;

  fetch_ibuf #(
    .W     (ENTRY_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_take),
    .push_data (ibuf_push_entry),
    .pop       (pop_fire),
    .head_data (ibuf_head_bits),
    .count     (ibuf_count)
  );

  assign ibuf_head   = entry_t'(ibuf_head_bits);
  assign out_instr   = ibuf_head.instr;
  assign out_pc      = ibuf_head.pc;
  assign out_pc_next = ibuf_head.pc + ADDR_W'(PC_INC);

  assign imem_req_valid = req_valid;
  assign imem_addr      = fetch_pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d, misaligned;

  assign misaligned = (redirect_pc % ADDR_W'(PC_INC)) != '0;

  always_comb begin
    err_d = err_q | (redirect_valid & misaligned);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign align_ok = ~err_q;
  assign err      = err_q;
`else
  assign align_ok = 1'b1;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit (default parameters).
// A fixed-latency memory model answers requests; a reference model tracks
// which addresses decode must see and when requests may issue.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        fetch_enable, redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        out_valid, out_ready;
  logic [15:0] out_instr, out_pc, out_pc_next;
  logic        err;

  fetch_unit #(
    .ADDR_W(16), .INSTR_W(16), .PC_INC(2), .RESET_PC(0), .IBUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .fetch_enable(fetch_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_next(out_pc_next), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [15:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  pend_t pend[$];
  int    cyc = 0;
  int    lat = 1;
  int    epoch = 0;
  int    rsp_epoch = -1;
  bit    rand_ready = 0;

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      imem_rsp_valid = 1'b0;
      if (rst) begin
        pend.delete();
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        rsp_epoch      = pend[0].epoch;
        void'(pend.pop_front());
      end
      imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- reference model + compare ----------------
  ibuf_entry_t pop_log[$];
  logic [15:0] pnext_log[$];
  int          pop_cyc[$];
  logic [15:0] issue_log[$];
  int          req_count = 0;

  logic [15:0] m_issue, m_out;
  int          m_live, m_buf;
  bit          m_err;
  bit          exp_req, exp_ov;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      m_issue = 16'h0000;
      m_out   = 16'h0000;
      m_live  = 0;
      m_buf   = 0;
      m_err   = 0;
      epoch++;
    end else begin
      // requests the live path may still have outstanding or buffered = issued - popped
      exp_req = fetch_enable && !redirect_valid && (m_live < DEPTH) && !m_err;
      exp_ov  = !redirect_valid && (m_buf > 0);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("err", 32'(err), 32'(m_err));
      if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_issue));
      if (exp_ov) begin
        chk("out_pc", 32'(out_pc), 32'(m_out));
        chk("out_instr", 32'(out_instr), 32'(mem_word(m_out)));
        chk("out_pc_next", 32'(out_pc_next), 32'(16'(m_out + 16'd2)));
      end
      // the memory sees whatever the DUT actually handed it
      if (imem_req_valid && imem_req_ready)
        pend.push_back('{addr: imem_addr, epoch: epoch, due: cyc + lat});

      if (redirect_valid) begin
        m_issue = redirect_pc;
        m_out   = redirect_pc;
        m_live  = 0;
        m_buf   = 0;
        epoch++;
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[0]) m_err = 1;
`endif
      end else begin
        if (exp_ov && out_ready) begin
          pop_log.push_back('{instr: out_instr, pc: out_pc});
          pnext_log.push_back(out_pc_next);
          pop_cyc.push_back(cyc);
          m_out = m_out + 16'd2;
          m_buf--;
          m_live--;
        end
        if (imem_rsp_valid && rsp_epoch == epoch) m_buf++;
        if (exp_req && imem_req_ready) begin
          issue_log.push_back(m_issue);
          req_count++;
          m_issue = m_issue + 16'd2;
          m_live++;
        end
      end
    end
  end

  function automatic logic [31:0] log_pc(input int i);
    return (i < pop_log.size()) ? 32'(pop_log[i].pc) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] log_instr(input int i);
    return (i < pop_log.size()) ? 32'(pop_log[i].instr) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] log_next(input int i);
    return (i < pnext_log.size()) ? 32'(pnext_log[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] log_issue(input int i);
    return (i < issue_log.size()) ? 32'(issue_log[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] log_cyc(input int i);
    return (i < pop_cyc.size()) ? 32'(pop_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    tick(2);
    pop_log.delete();
    pnext_log.delete();
    pop_cyc.delete();
    issue_log.delete();
    req_count = 0;
    rst = 1'b0;
  endtask

  int n_before;
  int req_snap;

  initial begin
    rst            = 1'b1;
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // 1: streaming, L=1
    lat = 1;
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b1;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stream_pc%0d", i), log_pc(i), 32'(2 * i));
      chk($sformatf("stream_next%0d", i), log_next(i), 32'(2 * i + 2));
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("stream_gap%0d", i), log_cyc(i + 1) - log_cyc(i), 32'd1);
    chk("stream_instr0", log_instr(0), 32'h0000_C3A5);
    chk("stream_instr1", log_instr(1), 32'h0000_C1A5);

    // 2: back-pressure fills the buffer, exactly DEPTH requests
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b0;
    tick(10);
    chk("bp_req_count", 32'(req_count), 32'd4);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    out_ready = 1'b1;
    tick(12);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_pc%0d", i), log_pc(i), 32'(2 * i));

    // 3: L=3, two in flight, redirect to 0x0100
    lat = 3;
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b1;
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    tick(1);
    redirect_valid = 1'b0;
    tick(12);
    chk("stale_issue", log_issue(2), 32'h0000_0100);
    chk("stale_pc0", log_pc(0), 32'h0000_0100);
    chk("stale_pc1", log_pc(1), 32'h0000_0102);

    // 4+5: redirect with response and pop in the same cycle, then PC wrap
    lat = 1;
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b1;
    tick(5);
    n_before = pop_log.size();
    chk("coinc_pops_before", 32'(n_before), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick(1);
    redirect_valid = 1'b0;
    chk("coinc_empty", 32'(out_valid), 32'd0);
    chk("coinc_no_pop", 32'(pop_log.size()), 32'(n_before));
    tick(8);
    chk("wrap_pc0", log_pc(n_before), 32'h0000_FFFE);
    chk("wrap_next0", log_next(n_before), 32'h0000_0000);
    chk("wrap_pc1", log_pc(n_before + 1), 32'h0000_0000);

    // 6: misaligned redirect
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b1;
    tick(3);
    n_before = pop_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0101;
    tick(1);
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_err", 32'(err), 32'd1);
    req_snap = req_count;
    tick(5);
    chk("align_no_req", 32'(req_count), 32'(req_snap));
    chk("align_req_valid", 32'(imem_req_valid), 32'd0);
`else
    chk("align_err_off", 32'(err), 32'd0);
    tick(5);
    chk("align_off_pc", log_pc(n_before), 32'h0000_0101);
`endif
    do_reset();
    tick(1);
    chk("err_cleared", 32'(err), 32'd0);

    // 7: randomised traffic, L=2, memory and decode stalls, random redirects
    lat = 2;
    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 80; i++) begin
      out_ready    = 1'($urandom_range(0, 1));
      fetch_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'($urandom) & 16'hFFFE;
      end else begin
        redirect_valid = 1'b0;
      end
      tick(1);
    end
    redirect_valid = 1'b0;
    rand_ready     = 0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
